// File: rtl/mac_layer_seq.sv
// mac_layer_seq: sequences one MLP layer on a single mac instance.
// For each output neuron it clears the accumulator, streams n_in (x, w) operand
// pairs from sync-read RAMs, drains the DSP pipeline, and presents the sum on a
// valid/ready output. The layer FSM above it sees a start/done interface.
// Optional feature macro: RELU_EN -- when defined, the captured neuron result
// goes through ReLU (a negative mac_dout stores 0).
// MAC_LAT must be at least 1.
module mac_layer_seq #(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 10,
  parameter int MAC_LAT = 2,
  parameter int DOUT_W  = 27
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_n_in,
  input  logic [CNT_W-1:0]  cfg_n_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              mac_xzero,
  input  logic [DOUT_W-1:0] mac_dout,
  output logic [DOUT_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  n_in_q, n_in_d;
  logic [CNT_W-1:0]  n_out_q, n_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mac_clear_q, mac_clear_d;
  logic              mac_en_q, mac_en_d;
  logic              mac_xzero_q, mac_xzero_d;
  logic [ADDR_W-1:0] x_addr_q, x_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DOUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_idx_q, out_idx_d;
  logic              out_valid_q, out_valid_d;

  logic              cfg_zero;
  logic              feed_last;
  logic              drain_last;
  logic              x_at_last;
  logic              more_neurons;
  logic [CNT_W:0]    idx_next;
  logic [ADDR_W-1:0] n_in_addr;
  logic [DOUT_W-1:0] captured;

  assign cfg_zero     = (cfg_n_in == '0) || (cfg_n_out == '0);
  assign feed_last    = (cnt_q == (n_in_q - CNT_W'(1)));
  assign drain_last   = (dcnt_q == DW'(MAC_LAT - 1));
  assign x_at_last    = (x_addr_q == ADDR_W'(n_in_q - CNT_W'(1)));
  assign idx_next     = {1'b0, out_idx_q} + (CNT_W+1)'(1);
  assign more_neurons = (idx_next < {1'b0, n_out_q});
  assign n_in_addr    = ADDR_W'(n_in_q);

  // Value loaded into out_data when entering OUT.
  always_comb begin
`ifdef RELU_EN
    captured = mac_dout[DOUT_W-1] ? '0 : mac_dout;
`else
    captured = mac_dout;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-output logic; every output is registered, so it is
  // computed here for the state being entered.
  always_comb begin
    state_d     = state_q;
    n_in_d      = n_in_q;
    n_out_d     = n_out_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    wbase_d     = wbase_q;
    x_addr_d    = x_addr_q;
    w_addr_d    = w_addr_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    mac_clear_d = 1'b0;
    mac_en_d    = 1'b0;
    mac_xzero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_in_d    = cfg_n_in;
          n_out_d   = cfg_n_out;
          out_idx_d = '0;
          wbase_d   = '0;
          if (cfg_zero) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d     = S_CLR;
            mac_clear_d = 1'b1;
            x_addr_d    = '0;
            w_addr_d    = '0;
          end
        end
      end

      S_CLR: begin
        state_d  = S_FEED;
        mac_en_d = 1'b1;
        cnt_d    = '0;
        if (!x_at_last) begin
          x_addr_d = x_addr_q + ADDR_W'(1);
          w_addr_d = w_addr_q + ADDR_W'(1);
        end
      end

      // Operand addresses run one cycle ahead of the consumed data and hold
      // at the last element once it has been issued.
      S_FEED: begin
        mac_en_d = 1'b1;
        if (feed_last) begin
          state_d     = S_DRAIN;
          mac_xzero_d = 1'b1;
          dcnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!x_at_last) begin
            x_addr_d = x_addr_q + ADDR_W'(1);
            w_addr_d = w_addr_q + ADDR_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (drain_last) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_data_d  = captured;
        end else begin
          mac_en_d    = 1'b1;
          mac_xzero_d = 1'b1;
          dcnt_d      = dcnt_q + DW'(1);
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (more_neurons) begin
            state_d     = S_CLR;
            out_idx_d   = idx_next[CNT_W-1:0];
            wbase_d     = wbase_q + n_in_addr;
            mac_clear_d = 1'b1;
            x_addr_d    = '0;
            w_addr_d    = wbase_q + n_in_addr;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_in_q      <= '0;
      n_out_q     <= '0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      wbase_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_clear_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_xzero_q <= 1'b0;
      x_addr_q    <= '0;
      w_addr_q    <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      n_in_q      <= n_in_d;
      n_out_q     <= n_out_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      wbase_q     <= wbase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mac_clear_q <= mac_clear_d;
      mac_en_q    <= mac_en_d;
      mac_xzero_q <= mac_xzero_d;
      x_addr_q    <= x_addr_d;
      w_addr_q    <= w_addr_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mac_clear = mac_clear_q;
  assign mac_en    = mac_en_q;
  assign mac_xzero = mac_xzero_q;
  assign x_addr    = x_addr_q;
  assign w_addr    = w_addr_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;

endmodule
